// File: rtl/mem_load_queue_pkg.sv
// Shared CPU load definitions: load-type encoding and word/offset widths
// used by the load queue, its bus interface and the alignment unit.
package mem_load_queue_pkg;

  localparam int WORD_W = 32;
  localparam int REG_W  = 5;
  localparam int OFF_W  = 2;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4,
    LD_LWL = 3'd5,
    LD_LWR = 3'd6
  } ld_type_e;

endpackage

// File: rtl/mem_load_queue_if.sv
// Bus between EX, the memory response port, WB and the load queue.
// The slave modport is the queue side; master is the surrounding pipeline.
interface mem_load_queue_if #(parameter int PC_W = 32) ();
  import mem_load_queue_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_mem;
  logic              in_gr_we;
  ld_type_e          in_ld_type;
  logic [OFF_W-1:0]  in_off;
  logic [WORD_W-1:0] in_rt;
  logic [WORD_W-1:0] in_alu;
  logic [REG_W-1:0]  in_dest;
  logic [PC_W-1:0]   in_pc;
  logic              data_ok;
  logic [WORD_W-1:0] rdata;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_result;
  logic [REG_W-1:0]  out_dest;
  logic              out_gr_we;
  logic [PC_W-1:0]   out_pc;
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_dest;
  logic [WORD_W-1:0] fwd_data;

  modport slave (
    input  in_valid, in_mem, in_gr_we, in_ld_type, in_off, in_rt, in_alu,
           in_dest, in_pc, data_ok, rdata, flush, out_ready,
    output in_ready, out_valid, out_result, out_dest, out_gr_we, out_pc,
           fwd_valid, fwd_dest, fwd_data
  );

  modport master (
    output in_valid, in_mem, in_gr_we, in_ld_type, in_off, in_rt, in_alu,
           in_dest, in_pc, data_ok, rdata, flush, out_ready,
    input  in_ready, out_valid, out_result, out_dest, out_gr_we, out_pc,
           fwd_valid, fwd_dest, fwd_data
  );

endinterface

// File: rtl/mem_load_queue_align.sv
// Combinational load alignment: selects/extends the addressed byte or half,
// and merges memory data with rt for the unaligned LWL/LWR pair.
module load_align import mem_load_queue_pkg::*; (
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] rt,
  input  ld_type_e          ld_type,
  input  logic [OFF_W-1:0]  off,
  output logic [WORD_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    result   = rdata;
    case (ld_type)
      LD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU: result = {24'h0, byte_sel};
      LD_LH:  result = {{16{half_sel[15]}}, half_sel};
      LD_LHU: result = {16'h0, half_sel};
      LD_LWL: begin
        case (off)
          2'd0:    result = {rdata[7:0],  rt[23:0]};
          2'd1:    result = {rdata[15:0], rt[15:0]};
          2'd2:    result = {rdata[23:0], rt[7:0]};
          default: result = rdata;
        endcase
      end
      LD_LWR: begin
        case (off)
          2'd0:    result = rdata;
          2'd1:    result = {rt[31:24], rdata[31:8]};
          2'd2:    result = {rt[31:16], rdata[31:16]};
          default: result = {rt[31:8],  rdata[31:24]};
        endcase
      end
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_load_queue.sv
// In-order load queue between EX and WB with in-order memory responses and
// flush-discard tracking. Define MEM_LOAD_FWD_EN to drive the head-forwarding port.
module mem_load_queue import mem_load_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic            clk,
  input logic            resetn,
  mem_load_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIS_W = CNT_W + 1;

  typedef struct packed {
    logic              mem;
    logic              gr_we;
    ld_type_e          ld_type;
    logic [OFF_W-1:0]  off;
    logic [WORD_W-1:0] rt;
    logic [WORD_W-1:0] alu;
    logic [REG_W-1:0]  dest;
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] data;
  } entry_t;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, resp_q, resp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DIS_W-1:0] discard_q, discard_d;
  logic [DEPTH-1:0] vld_q, vld_d, got_q, got_d;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];

  logic              found, deliver, drop, bypass, push, pop, out_valid;
  logic [PTR_W-1:0]  tgt, idx;
  logic [DIS_W-1:0]  pending;
  entry_t            head_ent;
  logic [WORD_W-1:0] align_word, aligned, result;

  load_align u_align (
    .rdata   (align_word),
    .rt      (head_ent.rt),
    .ld_type (head_ent.ld_type),
    .off     (head_ent.off),
    .result  (aligned)
  );

  // Oldest mem entry still waiting for data, walking forward from resp.
  always_comb begin
    found   = 1'b0;
    tgt     = resp_q;
    idx     = resp_q;
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = resp_q + PTR_W'(i);
      if (!found && vld_q[idx] && ent_q[idx].mem && !got_q[idx]) begin
        found = 1'b1;
        tgt   = idx;
      end
      if (vld_q[i] && ent_q[i].mem && !got_q[i]) pending = pending + DIS_W'(1);
    end
  end

  always_comb begin
    head_ent   = ent_q[head_q];
    drop       = bus.data_ok && (discard_q != '0);
    deliver    = bus.data_ok && (discard_q == '0) && found;
    bypass     = deliver && (tgt == head_q);
    out_valid  = vld_q[head_q] && (!head_ent.mem || got_q[head_q] || bypass) && !bus.flush;
    align_word = got_q[head_q] ? head_ent.data : bus.rdata;
    result     = !out_valid ? '0 : (head_ent.mem ? aligned : head_ent.alu);

    bus.in_ready   = (count_q < CNT_W'(DEPTH)) && !bus.flush;
    bus.out_valid  = out_valid;
    bus.out_result = result;
    bus.out_dest   = out_valid ? head_ent.dest : '0;
    bus.out_gr_we  = out_valid && head_ent.gr_we;
    bus.out_pc     = out_valid ? head_ent.pc : '0;
`ifdef MEM_LOAD_FWD_EN
    bus.fwd_valid  = out_valid && head_ent.gr_we;
    bus.fwd_dest   = bus.fwd_valid ? head_ent.dest : '0;
    bus.fwd_data   = bus.fwd_valid ? result : '0;
`else
    bus.fwd_valid  = 1'b0;
    bus.fwd_dest   = '0;
    bus.fwd_data   = '0;
`endif
    push = bus.in_valid && bus.in_ready;
    pop  = out_valid && bus.out_ready;
  end

  always_comb begin
    vld_d     = vld_q;
    got_d     = got_q;
    ent_d     = ent_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    discard_d = discard_q - DIS_W'(drop);
    resp_d    = deliver ? tgt + PTR_W'(1) : resp_q;
    if (deliver) begin
      got_d[tgt]      = 1'b1;
      ent_d[tgt].data = bus.rdata;
    end
    if (pop) begin
      vld_d[head_q] = 1'b0;
      got_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
      // resp must never be left pointing at a freed slot behind head.
      if (resp_d == head_q) resp_d = head_q + PTR_W'(1);
    end
    if (push) begin
      vld_d[tail_q]         = 1'b1;
      got_d[tail_q]         = 1'b0;
      ent_d[tail_q].mem     = bus.in_mem;
      ent_d[tail_q].gr_we   = bus.in_gr_we;
      ent_d[tail_q].ld_type = bus.in_ld_type;
      ent_d[tail_q].off     = bus.in_off;
      ent_d[tail_q].rt      = bus.in_rt;
      ent_d[tail_q].alu     = bus.in_alu;
      ent_d[tail_q].dest    = bus.in_dest;
      ent_d[tail_q].pc      = bus.in_pc;
      tail_d                = tail_q + PTR_W'(1);
    end
    if (bus.flush) begin
      vld_d     = '0;
      got_d     = '0;
      head_d    = '0;
      tail_d    = '0;
      resp_d    = '0;
      count_d   = '0;
      discard_d = discard_q - DIS_W'(drop) + pending - DIS_W'(deliver);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      resp_q    <= '0;
      count_q   <= '0;
      discard_q <= '0;
      vld_q     <= '0;
      got_q     <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      resp_q    <= resp_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      vld_q     <= vld_d;
      got_q     <= got_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_mem_load_queue.sv
// Directed bench for mem_load_queue: alignment cases, full/back-pressure,
// in-order completion, flush discard and asynchronous reset.
module tb_mem_load_queue;
  import mem_load_queue_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   n_total = 0;
  int   n_bad   = 0;

  mem_load_queue_if #(.PC_W(32)) bus ();

  mem_load_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #2;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_mem     = 1'b0;
    bus.in_gr_we   = 1'b0;
    bus.in_ld_type = LD_LW;
    bus.in_off     = 2'd0;
    bus.in_rt      = 32'h0;
    bus.in_alu     = 32'h0;
    bus.in_dest    = 5'd0;
    bus.in_pc      = 32'h0;
    bus.data_ok    = 1'b0;
    bus.rdata      = 32'h0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic set_in(input logic mem, input ld_type_e t, input logic [1:0] off,
                        input logic [31:0] rt, input logic [31:0] alu, input logic [4:0] dest);
    bus.in_valid   = 1'b1;
    bus.in_mem     = mem;
    bus.in_gr_we   = 1'b1;
    bus.in_ld_type = t;
    bus.in_off     = off;
    bus.in_rt      = rt;
    bus.in_alu     = alu;
    bus.in_dest    = dest;
    bus.in_pc      = {24'h0, 3'b0, dest} << 2;
  endtask

  // Push one load, then return its data with out_ready high: bypass completion.
  task automatic one_load(input string tag, input ld_type_e t, input logic [1:0] off,
                          input logic [31:0] rt, input logic [31:0] w, input logic [31:0] exp);
    set_in(1'b1, t, off, rt, 32'h0, 5'd7);
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    bus.data_ok  = 1'b1;
    bus.rdata    = w;
    mid();
    chk_val({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk_val({tag, "_res"}, bus.out_result, exp);
`ifdef MEM_LOAD_FWD_EN
    chk_val({tag, "_fwd"}, bus.fwd_data, exp);
`else
    chk_val({tag, "_fwd"}, 32'(bus.fwd_valid), 32'd0);
`endif
    cyc();
    bus.data_ok = 1'b0;
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    cyc();
    mid();
    chk_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_val("rst_result", bus.out_result, 32'h0);
    resetn = 1'b1;
    cyc();
    mid();
    chk_val("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk_val("rel_out_valid", 32'(bus.out_valid), 32'd0);
    chk_val("rel_fwd_valid", 32'(bus.fwd_valid), 32'd0);
    cyc();

    // Alignment table
    one_load("lb3",   LD_LB,  2'd3, 32'h0,        32'h80FFFFFF, 32'hFFFFFF80);
    one_load("lb0",   LD_LB,  2'd0, 32'h0,        32'h0000007F, 32'h0000007F);
    one_load("lbu1",  LD_LBU, 2'd1, 32'h0,        32'h00008000, 32'h00000080);
    one_load("lh2",   LD_LH,  2'd2, 32'h0,        32'h80001234, 32'hFFFF8000);
    one_load("lhu0",  LD_LHU, 2'd0, 32'h0,        32'h0000F00D, 32'h0000F00D);
    one_load("lw",    LD_LW,  2'd0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
    one_load("lwl1",  LD_LWL, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'h3344CCDD);
    one_load("lwr2",  LD_LWR, 2'd2, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122);
    one_load("lwl0",  LD_LWL, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h44BBCCDD);
    one_load("lwr3",  LD_LWR, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'hAABBCC11);
    one_load("lwl3",  LD_LWL, 2'd3, 32'hAABBCCDD, 32'h11223344, 32'h11223344);
    one_load("lwr0",  LD_LWR, 2'd0, 32'hAABBCCDD, 32'h11223344, 32'h11223344);
    one_load("lwr1",  LD_LWR, 2'd1, 32'hAABBCCDD, 32'h11223344, 32'hAA112233);

    // Fill to DEPTH with out_ready low; the fifth request must wait.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, LD_LW, 2'd0, 32'h0, 32'h0, 5'(i + 1));
      mid();
      chk_val($sformatf("fill_ready%0d", i), 32'(bus.in_ready), 32'd1);
      cyc();
    end
    set_in(1'b1, LD_LW, 2'd0, 32'h0, 32'h0, 5'd31);
    mid();
    chk_val("full_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.data_ok = 1'b1;
      bus.rdata   = 32'hA0 + 32'(i);
      mid();
      chk_val($sformatf("drain_res%0d", i), bus.out_result, 32'hA0 + 32'(i));
      chk_val($sformatf("drain_dest%0d", i), 32'(bus.out_dest), 32'(i + 1));
      cyc();
    end
    bus.data_ok = 1'b0;
    mid();
    chk_val("drain_empty", 32'(bus.out_valid), 32'd0);
    cyc();

    // Non-mem ahead of a mem load; data arrives while head is non-mem.
    bus.out_ready = 1'b0;
    set_in(1'b0, LD_LW, 2'd0, 32'h0, 32'h5, 5'd3);
    cyc();
    set_in(1'b1, LD_LW, 2'd0, 32'h0, 32'h0, 5'd4);
    cyc();
    bus.in_valid = 1'b0;
    bus.data_ok  = 1'b1;
    bus.rdata    = 32'h1234;
    mid();
    chk_val("order_head_res", bus.out_result, 32'h5);
    cyc();
    bus.data_ok   = 1'b0;
    bus.out_ready = 1'b1;
    mid();
    chk_val("order_first", bus.out_result, 32'h5);
    cyc();
    mid();
    chk_val("order_second_vld", 32'(bus.out_valid), 32'd1);
    chk_val("order_second", bus.out_result, 32'h1234);
    cyc();
    mid();
    chk_val("order_empty", 32'(bus.out_valid), 32'd0);
    cyc();

    // Flush with a completed non-mem head and two pending loads.
    bus.out_ready = 1'b0;
    set_in(1'b0, LD_LW, 2'd0, 32'h0, 32'h77, 5'd2);
    cyc();
    set_in(1'b1, LD_LW, 2'd0, 32'h0, 32'h0, 5'd5);
    cyc();
    set_in(1'b1, LD_LW, 2'd0, 32'h0, 32'h0, 5'd6);
    cyc();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    mid();
    chk_val("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk_val("flush_in_ready", 32'(bus.in_ready), 32'd0);
    chk_val("flush_fwd_valid", 32'(bus.fwd_valid), 32'd0);
    cyc();
    bus.flush = 1'b0;
    mid();
    chk_val("flush_discard", 32'(dut.discard_q), 32'd2);
    chk_val("flush_empty", 32'(bus.out_valid), 32'd0);
    set_in(1'b1, LD_LW, 2'd0, 32'h0, 32'h0, 5'd9);
    bus.data_ok = 1'b1;
    bus.rdata   = 32'hBAD1;
    cyc();
    bus.in_valid  = 1'b0;
    bus.rdata     = 32'hBAD2;
    bus.out_ready = 1'b1;
    mid();
    chk_val("discard_drop2", 32'(bus.out_valid), 32'd0);
    cyc();
    bus.rdata = 32'h600D;
    mid();
    chk_val("after_discard_vld", 32'(bus.out_valid), 32'd1);
    chk_val("after_discard_res", bus.out_result, 32'h600D);
    chk_val("after_discard_dest", 32'(bus.out_dest), 32'd9);
    cyc();
    bus.data_ok = 1'b0;

    // Flush in the same cycle as a serving data_ok: only one discard owed.
    bus.out_ready = 1'b0;
    set_in(1'b1, LD_LW, 2'd0, 32'h0, 32'h0, 5'd10);
    cyc();
    set_in(1'b1, LD_LW, 2'd0, 32'h0, 32'h0, 5'd11);
    cyc();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    bus.data_ok  = 1'b1;
    bus.rdata    = 32'h1;
    cyc();
    bus.flush = 1'b0;
    mid();
    chk_val("flush_served_discard", 32'(dut.discard_q), 32'd1);
    cyc();
    mid();
    chk_val("flush_served_cleared", 32'(dut.discard_q), 32'd0);
    cyc();
    bus.data_ok = 1'b0;

    // Asynchronous reset with three entries in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, LD_LW, 2'd0, 32'h0, 32'h100 + 32'(i), 5'(12 + i));
      cyc();
    end
    bus.in_valid = 1'b0;
    mid();
    chk_val("pre_reset_vld", 32'(bus.out_valid), 32'd1);
    chk_val("pre_reset_res", bus.out_result, 32'h100);
    resetn = 1'b0;
    #1;
    chk_val("async_rst_vld", 32'(bus.out_valid), 32'd0);
    chk_val("async_rst_res", bus.out_result, 32'h0);
    cyc();
    resetn = 1'b1;
    mid();
    chk_val("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk_val("post_rst_vld", 32'(bus.out_valid), 32'd0);
    cyc();
    set_in(1'b0, LD_LW, 2'd0, 32'h0, 32'h42, 5'd20);
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    mid();
    chk_val("post_rst_res", bus.out_result, 32'h42);
    chk_val("post_rst_pc", bus.out_pc, 32'd80);
    cyc();
    mid();
    chk_val("post_rst_empty", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_load_queue.md
MEM_LOAD_QUEUE -- requirements
Module: mem_load_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning max in-flight entries (power of two, 2..8).
REQ-002 SHALL have parameter PC_W, default 32, meaning PC/address width carried per entry.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports in_valid/in_ready  in/out  1  entry handshake from EX.
REQ-006 SHALL have ports in_mem, in_gr_we  in  1  entry awaits data_ok; entry writes GPR.
REQ-007 SHALL have ports in_ld_type  in  3  load kind (package enum); in_off  in  2  byte offset.
REQ-008 SHALL have ports in_rt, in_alu  in  32  rt value for LWL/LWR; ALU result.
REQ-009 SHALL have ports in_dest  in  5  and in_pc  in  PC_W.
REQ-010 SHALL have ports data_ok  in  1  and rdata  in  32  in-order memory response.
REQ-011 SHALL have port flush  in  1  exception/ERET cancel of all entries.
REQ-012 SHALL have ports out_valid/out_ready  out/in  1  to WB; out_result  out  32; out_dest  out  5; out_gr_we  out  1; out_pc  out  PC_W.
REQ-013 SHALL have ports fwd_valid  out  1, fwd_dest  out  5, fwd_data  out  32  (forwarding of head).

Function
REQ-014 SHALL store entries in a circular FIFO of DEPTH slots with head, tail, resp pointers and count (width clog2(DEPTH)+1).
REQ-015 in_ready SHALL equal count<DEPTH && !flush; a push SHALL occur on in_valid&&in_ready; no push when full, even with a pop in the same cycle.
REQ-016 Entry is complete when in_mem=0, or when its data has been captured.
REQ-017 data_ok SHALL deliver to the oldest mem entry without data (resp pointer), skipping non-mem entries; data_ok with no such entry and discard=0 SHALL be ignored.
REQ-018 out_valid SHALL be 1 when head is complete, or when head is a mem entry awaiting data and data_ok=1 this cycle (zero-cycle bypass using rdata).
REQ-019 Pop SHALL occur on out_valid&&out_ready; count SHALL update by push minus pop each cycle.
REQ-020 out_result SHALL be in_alu for non-mem; otherwise aligned data: LB/LBU sign/zero-extend byte[off]; LH/LHU half[off[1]]; LW whole word; LWL off0..3 = {b0,rt[23:0]},{h0,rt[15:0]},{b2..0,rt[7:0]},word; LWR off0..3 = word,{rt[31:24],w[31:8]},{rt[31:16],w[31:16]},{rt[31:8],w[31:24]}.
REQ-021 Flush SHALL empty the queue next cycle and set discard = number of mem entries still lacking data, excluding any served by a same-cycle data_ok.
REQ-022 While discard>0, each data_ok SHALL be dropped and decrement discard; data_ok reaches new entries only when discard=0.
REQ-023 Pointers SHALL wrap modulo DEPTH.
REQ-024 out_valid, fwd_valid SHALL be 0 in the flush cycle.

Reset
REQ-025 resetn low SHALL asynchronously clear pointers, count, discard and slot valid bits; out_valid=0, in_ready=1 after release, all data outputs 0.
REQ-026 Reset mid-operation SHALL drop all entries and pending discards without further handshakes.

Configuration
REQ-027 Macro MEM_LOAD_FWD_EN defined: fwd_valid=head valid&&gr_we&&(complete||bypass), fwd_dest=head dest, fwd_data=out_result.
REQ-028 Macro undefined: fwd_valid, fwd_dest, fwd_data SHALL be tied 0; ports remain.

Structure
REQ-029 Load-type enum (LB,LBU,LH,LHU,LW,LWL,LWR) and width constants SHALL live in the shared CPU package.
REQ-030 Alignment/extension SHALL be a combinational sub-module load_align (rdata, rt, type, off -> result).

Verification
REQ-031 Push LB off=3, rdata=0x80FFFFFF same cycle data_ok, out_ready=1 -> out_valid that cycle, out_result=0xFFFFFF80.
REQ-032 Push 4 mem entries, out_ready=0 -> in_ready=0 at count 4; 5th in_valid not accepted.
REQ-033 Push non-mem (alu=5), mem LW; data_ok rdata=0x1234 while head is non-mem -> outputs 5 then 0x1234 in order.
REQ-034 Two mem entries pending, flush -> discard=2; next two data_ok dropped; new LW then receives third data_ok.
REQ-035 LWL off=1, rt=0xAABBCCDD, rdata=0x11223344 -> 0x3344CCDD; LWR off=2 -> 0xAABB1122.
REQ-036 resetn low while count=3 -> out_valid=0 immediately, in_ready=1 after release.
